conv_schedule_ctrl: RTL and testbench
=====================================

# conv_schedule_ctrl

Sequencer for the spatial convolution datapath. It steps a shared single-channel convolution kernel and channel accumulator over every (output kernel, input channel) pair for each input window. It handshakes per channel with the input window buffers and the weight source, and honours per-kernel backpressure from the pooling stage. It sits between the per-channel window buffers and weight feeders on one side and the accumulator and pool window buffers on the other.

## Interface
- N_ROWS, 28, input feature map rows
- N_COLS, 28, input feature map columns
- N_CHANNELS, 1, input channels
- N_KERNELS, 32, output kernels
- KERNEL_SIZE, 3, square window side; stride fixed at 1
- Derived: CW = max(1, clog2(N_CHANNELS)); KW = max(1, clog2(N_KERNELS)); NW = (N_ROWS-KERNEL_SIZE+1)*(N_COLS-KERNEL_SIZE+1) windows per frame
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-high
- window_valid_i  in  N_CHANNELS  bit c: window buffer c holds a valid window
- kernel_valid_i  in  N_CHANNELS  bit c: weights for (kernel_sel_o, c) are valid
- hold_i  in  N_KERNELS  bit k: downstream of kernel k cannot accept a result
- channel_sel_o  out  CW  channel routed to the conv kernel
- kernel_sel_o  out  KW  output kernel currently computed
- acc_en_o  out  1  accumulator captures the conv result this cycle
- acc_clear_o  out  1  with acc_en_o: load instead of add (first channel)
- kernel_ack_o  out  N_CHANNELS  one-hot pulse: weight word for the channel consumed
- conv_valid_o  out  N_KERNELS  one-hot pulse: accumulator holds the final sum for kernel k
- window_release_o  out  N_CHANNELS  all-ones pulse: every window buffer may advance
- frame_done_o  out  1  pulse on release of the last window of a frame
- busy_o  out  1  high when state != WAIT

## Operation
- States: WAIT, MAC, EMIT. Internal counters: k (0..N_KERNELS-1), c (0..N_CHANNELS-1), w (0..NW-1).
- channel_sel_o = c. kernel_sel_o = k.
- All other outputs are registered Moore outputs. Each is 0 except as listed below.
- **WAIT**
  - Advance condition: window_valid_i[c] && kernel_valid_i[c] && !hold_i[k] → MAC.
  - Otherwise stay in WAIT. No output pulses.
- **MAC** (exactly one cycle)
  - acc_en_o=1; acc_clear_o=(c==0); kernel_ack_o[c]=1.
  - If c<N_CHANNELS-1: c←c+1, go to WAIT.
  - Else: go to EMIT; c is held.
- **EMIT** (exactly one cycle)
  - conv_valid_o[k]=1; c←0.
  - If k<N_KERNELS-1: k←k+1.
  - Else: k←0; window_release_o=all ones; w←w+1.
  - If w==NW-1: additionally frame_done_o=1 and w←0.
  - Go to WAIT.
- hold_i is sampled only in WAIT, and only bit k. A hold asserted during MAC or EMIT does not suppress that cycle's pulses.
- Only one bit of hold_i matters per stall. Holds on other kernels are ignored.
- kernel_valid_i and window_valid_i are level signals. The controller never acks a word it did not see valid in the preceding WAIT cycle.
- Counters wrap exactly at their bounds. No value reaches N_KERNELS, N_CHANNELS or NW.

## Timing
- Reset (synchronous): state=WAIT; k=c=w=0; all pulse outputs 0; busy_o=0. channel_sel_o=0 and kernel_sel_o=0 in the cycle after reset_i is sampled high.
- Reset during MAC or EMIT aborts the current window. Pending pulses do not appear after reset.
- Throughput with all inputs ready: 2 cycles per channel plus 1 EMIT cycle per kernel.
  - Per window: N_KERNELS*(2*N_CHANNELS+1) cycles.
- Latency from the ready condition in WAIT to the acc_en_o pulse: 1 cycle.
- Latency from the last channel's MAC to conv_valid_o: 1 cycle.
- The accumulator updates at the end of a MAC cycle. The consumer samples it while conv_valid_o is high.
- Simultaneous hold_i and valid inputs: hold wins; stay in WAIT.

## Test plan
- **Single-channel baseline.** N_CHANNELS=1, N_KERNELS=2; all valids high, hold low, reset released before cycle 0.
  - MAC at cycles 1 and 4, each with acc_clear_o=1.
  - conv_valid_o=01 at cycle 2 and 10 at cycle 5.
  - window_release_o at cycle 5.
- **Three channels.** N_CHANNELS=3, all ready. Per kernel:
  - acc_en_o three times, with acc_clear_o only on the first.
  - kernel_ack_o sequence 001, 010, 100.
  - conv_valid_o once, 7 cycles per kernel.
- **Backpressure.** hold_i[1]=1 for 10 cycles after the kernel 0 EMIT:
  - No acc_en_o or kernel_ack_o during the hold.
  - MAC for k=1 on the cycle after hold_i[1] falls.
  - hold_i[0] toggling during the same interval has no effect.
- **Weight starvation.** kernel_valid_i[1]=0 while c=1: stalls in WAIT with channel_sel_o=1; resumes when it returns high.
- **Frame wrap.** N_ROWS=N_COLS=4, KERNEL_SIZE=3 (NW=4):
  - frame_done_o only with the 4th window_release_o.
  - The 5th window starts at k=0 with w=0.
- **Mid-operation reset.** reset_i asserted in a MAC cycle with c=1, k=3:
  - Next cycle: all outputs 0, selects 0, busy_o=0.
  - Normal sequence restarts from k=0, c=0.

Source files
------------

// File: rtl/conv_schedule_ctrl_if.sv
// -----------------------------------------------------------------------------
// conv_schedule_ctrl_if
//
// Purpose : Groups the handshake and steering signals of the convolution
//           schedule controller into one bundle.
//
// Signals :
//   window_valid_i   [N_CHANNELS] window buffer c holds a valid window
//   kernel_valid_i   [N_CHANNELS] weights for (kernel_sel_o, c) are valid
//   hold_i           [N_KERNELS]  downstream of kernel k cannot accept a result
//   channel_sel_o    [CW]         channel routed to the conv kernel
//   kernel_sel_o     [KW]         output kernel currently computed
//   acc_en_o                      accumulator captures the conv result
//   acc_clear_o                   with acc_en_o: load instead of add
//   kernel_ack_o     [N_CHANNELS] one-hot: weight word for channel consumed
//   conv_valid_o     [N_KERNELS]  one-hot: accumulator holds final sum for k
//   window_release_o [N_CHANNELS] all-ones: every window buffer may advance
//   frame_done_o                  release of the last window of a frame
//   busy_o                        controller is not waiting
//
// Modports: master = controller side, slave = surrounding datapath side.
// -----------------------------------------------------------------------------
interface conv_schedule_ctrl_if #(
   parameter int N_CHANNELS = 1,
   parameter int N_KERNELS  = 32
);
   localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int KW = (N_KERNELS  > 1) ? $clog2(N_KERNELS)  : 1;

   logic [N_CHANNELS-1:0] window_valid_i;
   logic [N_CHANNELS-1:0] kernel_valid_i;
   logic [N_KERNELS-1:0]  hold_i;
   logic [CW-1:0]         channel_sel_o;
   logic [KW-1:0]         kernel_sel_o;
   logic                  acc_en_o;
   logic                  acc_clear_o;
   logic [N_CHANNELS-1:0] kernel_ack_o;
   logic [N_KERNELS-1:0]  conv_valid_o;
   logic [N_CHANNELS-1:0] window_release_o;
   logic                  frame_done_o;
   logic                  busy_o;

   modport master (
      input  window_valid_i, kernel_valid_i, hold_i,
      output channel_sel_o, kernel_sel_o, acc_en_o, acc_clear_o,
             kernel_ack_o, conv_valid_o, window_release_o,
             frame_done_o, busy_o
   );

   modport slave (
      output window_valid_i, kernel_valid_i, hold_i,
      input  channel_sel_o, kernel_sel_o, acc_en_o, acc_clear_o,
             kernel_ack_o, conv_valid_o, window_release_o,
             frame_done_o, busy_o
   );
endinterface

// File: rtl/conv_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// conv_schedule_ctrl
//
// Purpose : Sequences a shared single-channel convolution kernel and channel
//           accumulator over every (output kernel, input channel) pair of each
//           input window. For each pair it waits for the channel's window and
//           weights plus a free downstream slot for the kernel, issues one
//           accumulate cycle, and after the last channel emits the kernel's
//           result. After the last kernel it releases the window buffers and
//           counts windows to flag the end of a frame.
//
// Ports   :
//   clock_i  single clock, rising edge
//   reset_i  synchronous, active-high
//   bus      conv_schedule_ctrl_if.master (handshake / steering bundle)
//
// Every output is registered; channel_sel_o and kernel_sel_o are the live
// channel and kernel counters.
// -----------------------------------------------------------------------------
module conv_schedule_ctrl #(
   parameter int N_ROWS      = 28,
   parameter int N_COLS      = 28,
   parameter int N_CHANNELS  = 1,
   parameter int N_KERNELS   = 32,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   conv_schedule_ctrl_if.master bus
);

   localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam int KW = (N_KERNELS  > 1) ? $clog2(N_KERNELS)  : 1;
   localparam int NW = (N_ROWS - KERNEL_SIZE + 1) * (N_COLS - KERNEL_SIZE + 1);
   localparam int WW = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [CW-1:0]         C_LAST = CW'(N_CHANNELS - 1);
   localparam logic [KW-1:0]         K_LAST = KW'(N_KERNELS - 1);
   localparam logic [WW-1:0]         W_LAST = WW'(NW - 1);
   localparam logic [N_CHANNELS-1:0] CH_ONE = N_CHANNELS'(1);
   localparam logic [N_KERNELS-1:0]  KN_ONE = N_KERNELS'(1);

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      MAC  = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [KW-1:0] k_q, k_d;
   logic [CW-1:0] c_q, c_d;
   logic [WW-1:0] w_q, w_d;

   logic                  acc_en_q,         acc_en_d;
   logic                  acc_clear_q,      acc_clear_d;
   logic [N_CHANNELS-1:0] kernel_ack_q,     kernel_ack_d;
   logic [N_KERNELS-1:0]  conv_valid_q,     conv_valid_d;
   logic [N_CHANNELS-1:0] window_release_q, window_release_d;
   logic                  frame_done_q,     frame_done_d;
   logic                  busy_q,           busy_d;

   // One-hot decodes of the counters; masking with them avoids bit-selecting
   // the input vectors with a counter that may be wider than needed.
   logic [N_CHANNELS-1:0] c_onehot;
   logic [N_KERNELS-1:0]  k_onehot;
   logic                  pair_ready;

   assign c_onehot   = CH_ONE << c_q;
   assign k_onehot   = KN_ONE << k_q;
   // Only the current kernel's hold bit can stall; hold beats valid.
   assign pair_ready = (|(bus.window_valid_i & bus.kernel_valid_i & c_onehot))
                       && !(|(bus.hold_i & k_onehot));

   // Next-state, counter and output-pulse logic. The pulse outputs are
   // computed for the state being entered so that, once registered, they line
   // up exactly with the MAC / EMIT cycle they belong to.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d          = state_q;
      k_d              = k_q;
      c_d              = c_q;
      w_d              = w_q;
      acc_en_d         = 1'b0;
      acc_clear_d      = 1'b0;
      kernel_ack_d     = '0;
      conv_valid_d     = '0;
      window_release_d = '0;
      frame_done_d     = 1'b0;

      unique case (state_q)
         WAIT: begin
            if (pair_ready) begin
               state_d      = MAC;
               acc_en_d     = 1'b1;
               acc_clear_d  = (c_q == '0);
               kernel_ack_d = c_onehot;
            end
         end

         MAC: begin
            if (c_q == C_LAST) begin
               // Last channel accumulated: the sum is final in the next cycle.
               state_d      = EMIT;
               conv_valid_d = k_onehot;
               if (k_q == K_LAST) begin
                  window_release_d = '1;
                  frame_done_d     = (w_q == W_LAST);
               end
            end else begin
               state_d = WAIT;
               c_d     = c_q + 1'b1;
            end
         end

         EMIT: begin
            state_d = WAIT;
            c_d     = '0;
            if (k_q == K_LAST) begin
               k_d = '0;
               w_d = (w_q == W_LAST) ? '0 : w_q + 1'b1;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         default: begin
            state_d = WAIT;
         end
      endcase

      busy_d = (state_d != WAIT);
   end

   // NOTE: state and registered outputs use non-blocking assignments so all
   // of them update together on the edge, independent of statement order.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q          <= WAIT;
         k_q              <= '0;
         c_q              <= '0;
         w_q              <= '0;
         acc_en_q         <= 1'b0;
         acc_clear_q      <= 1'b0;
         kernel_ack_q     <= '0;
         conv_valid_q     <= '0;
         window_release_q <= '0;
         frame_done_q     <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         k_q              <= k_d;
         c_q              <= c_d;
         w_q              <= w_d;
         acc_en_q         <= acc_en_d;
         acc_clear_q      <= acc_clear_d;
         kernel_ack_q     <= kernel_ack_d;
         conv_valid_q     <= conv_valid_d;
         window_release_q <= window_release_d;
         frame_done_q     <= frame_done_d;
         busy_q           <= busy_d;
      end
   end

   assign bus.channel_sel_o    = c_q;
   assign bus.kernel_sel_o     = k_q;
   assign bus.acc_en_o         = acc_en_q;
   assign bus.acc_clear_o      = acc_clear_q;
   assign bus.kernel_ack_o     = kernel_ack_q;
   assign bus.conv_valid_o     = conv_valid_q;
   assign bus.window_release_o = window_release_q;
   assign bus.frame_done_o     = frame_done_q;
   assign bus.busy_o           = busy_q;

endmodule

// File: tb/tb_conv_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_schedule_ctrl
//
// Bench for conv_schedule_ctrl with 3 channels, 4 kernels and a 4x4 map with a
// 3x3 window (4 windows per frame). The reference model walks a flat per-window
// work list (for each kernel: one entry per channel, then one emit entry) and
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_conv_schedule_ctrl;

   localparam int NR  = 4;
   localparam int NCO = 4;
   localparam int KS  = 3;
   localparam int NC  = 3;
   localparam int NK  = 4;
   localparam int NW  = (NR - KS + 1) * (NCO - KS + 1);
   localparam int L   = NK * (NC + 1);   // work-list entries per window

   logic clk;
   logic rst;

   conv_schedule_ctrl_if #(.N_CHANNELS(NC), .N_KERNELS(NK)) bus ();

   conv_schedule_ctrl #(
      .N_ROWS(NR), .N_COLS(NCO), .N_CHANNELS(NC),
      .N_KERNELS(NK), .KERNEL_SIZE(KS)
   ) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {A_GATE, A_MAC, A_EMIT} act_t;
   act_t m_act = A_GATE;   // what the controller is doing this cycle
   int   m_pos = 0;        // index into the work list of the current window
   int   m_win = 0;        // window index within the frame

   function automatic int cur_k();
      return m_pos / (NC + 1);
   endfunction

   function automatic int cur_r();
      return m_pos % (NC + 1);
   endfunction

   // Apply inputs for one cycle, clock, advance the model, compare everything.
   task automatic step(input logic [NC-1:0] wv, input logic [NC-1:0] kv,
                       input logic [NK-1:0] hold, input logic r);
      int k;
      int c;
      logic [31:0] e_ack, e_cv, e_rel;
      bus.window_valid_i = wv;
      bus.kernel_valid_i = kv;
      bus.hold_i         = hold;
      rst                = r;
      @(posedge clk);
      #1;
      if (r) begin
         m_act = A_GATE;
         m_pos = 0;
         m_win = 0;
      end else begin
         case (m_act)
            A_GATE: if (wv[cur_r()] && kv[cur_r()] && !hold[cur_k()]) m_act = A_MAC;
            A_MAC: begin
               m_pos++;
               m_act = (cur_r() == NC) ? A_EMIT : A_GATE;
            end
            default: begin
               m_pos++;
               if (m_pos == L) begin
                  m_pos = 0;
                  m_win = (m_win + 1) % NW;
               end
               m_act = A_GATE;
            end
         endcase
      end
      k     = cur_k();
      c     = (m_act == A_EMIT) ? NC - 1 : cur_r();
      e_ack = (m_act == A_MAC)  ? (32'd1 << c) : 32'd0;
      e_cv  = (m_act == A_EMIT) ? (32'd1 << k) : 32'd0;
      e_rel = (m_act == A_EMIT && k == NK - 1) ? ((32'd1 << NC) - 1) : 32'd0;
      check("channel_sel",    32'(bus.channel_sel_o),    32'(c));
      check("kernel_sel",     32'(bus.kernel_sel_o),     32'(k));
      check("acc_en",         32'(bus.acc_en_o),         32'(m_act == A_MAC));
      check("acc_clear",      32'(bus.acc_clear_o),      32'(m_act == A_MAC && c == 0));
      check("kernel_ack",     32'(bus.kernel_ack_o),     e_ack);
      check("conv_valid",     32'(bus.conv_valid_o),     e_cv);
      check("window_release", 32'(bus.window_release_o), e_rel);
      check("frame_done",     32'(bus.frame_done_o),
            32'(e_rel != 0 && m_win == NW - 1));
      check("busy",           32'(bus.busy_o),           32'(m_act != A_GATE));
   endtask

   localparam logic [NC-1:0] ALL_C = '1;
   localparam logic [NK-1:0] NO_H  = '0;

   initial begin
      int n;
      int rel_cnt;
      int fd_cnt;
      logic [NC-1:0] wv, kv;
      logic [NK-1:0] h;

      bus.window_valid_i = '0;
      bus.kernel_valid_i = '0;
      bus.hold_i         = '0;
      rst                = 1'b1;

      // Reset state.
      repeat (3) step('0, '0, '0, 1'b1);

      // Free-running: covers three-channel order and frame wrap.
      rel_cnt = 0;
      fd_cnt  = 0;
      for (int i = 0; i < 6 * L * NW; i++) begin
         step(ALL_C, ALL_C, NO_H, 1'b0);
         if (bus.window_release_o != 0) rel_cnt++;
         if (bus.frame_done_o) begin
            fd_cnt++;
            check("frame_done_on_4th_release", 32'(rel_cnt % NW), 32'd0);
         end
      end
      check("frame_done_count", 32'(fd_cnt), 32'(rel_cnt / NW));

      // Backpressure: hold kernel 1 for 10 cycles after kernel 0's emit,
      // toggling hold on kernel 0 meanwhile.
      n = 0;
      while (!(m_act == A_EMIT && cur_k() == 0) && n < 200) begin
         step(ALL_C, ALL_C, NO_H, 1'b0);
         n++;
      end
      check("reach_k0_emit", 32'(n < 200), 32'd1);
      for (int i = 0; i < 10; i++) begin
         h = NK'(2 | (i % 2));
         step(ALL_C, ALL_C, h, 1'b0);
         check("bp_no_acc_en", 32'(bus.acc_en_o), 32'd0);
      end
      step(ALL_C, ALL_C, NO_H, 1'b0);
      check("bp_resume_mac", 32'(bus.acc_en_o), 32'd1);
      check("bp_resume_k",   32'(bus.kernel_sel_o), 32'd1);

      // Weight starvation on channel 1.
      n = 0;
      while (!(m_act == A_GATE && cur_r() == 1) && n < 200) begin
         step(ALL_C, ALL_C, NO_H, 1'b0);
         n++;
      end
      check("reach_gate_c1", 32'(n < 200), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(ALL_C, 3'b101, NO_H, 1'b0);
         check("starve_sel", 32'(bus.channel_sel_o), 32'd1);
         check("starve_idle", 32'(bus.acc_en_o), 32'd0);
      end
      step(ALL_C, ALL_C, NO_H, 1'b0);
      check("starve_resume", 32'(bus.kernel_ack_o), 32'b010);

      // Mid-operation reset in the MAC of k=3, c=1.
      n = 0;
      while (!(m_act == A_MAC && cur_k() == 3 && cur_r() == 1) && n < 400) begin
         step(ALL_C, ALL_C, NO_H, 1'b0);
         n++;
      end
      check("reach_mac_k3c1", 32'(n < 400), 32'd1);
      step(ALL_C, ALL_C, NO_H, 1'b1);
      check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
      check("rst_mid_conv", 32'(bus.conv_valid_o), 32'd0);
      repeat (2 * L) step(ALL_C, ALL_C, NO_H, 1'b0);

      // Randomized stimulus.
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NC; b++) begin
            wv[b] = ($urandom_range(0, 7) != 0);
            kv[b] = ($urandom_range(0, 7) != 0);
         end
         for (int b = 0; b < NK; b++) h[b] = ($urandom_range(0, 3) == 0);
         step(wv, kv, h, ($urandom_range(0, 299) == 0));
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
